ext_irq_ctrl: RTL and testbench
===============================

# ext_irq_ctrl

External interrupt controller driving the core's machine external interrupt request (meip) and consuming the core's one-cycle interrupt acknowledge (irq_ack). It collects NUM_SRC asynchronous device interrupt lines and synchronizes them. It latches each line as edge- or level-triggered pending state and arbitrates by fixed priority, where the lowest index wins. A claim/complete handshake gives the trap handler the winning source ID; software configures and services the block through a small memory-mapped register port.

## Interface
- NUM_SRC, 16, number of interrupt sources (1..31); source IDs are 1..NUM_SRC, ID 0 means "none"
- clk  input  1  core clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- src_irq  input  NUM_SRC  device interrupt lines, asynchronous, bit k is source ID k+1
- irq_ack  input  1  one-cycle pulse from the CSR unit when it takes the external interrupt
- meip  output  1  registered external interrupt request to the CSR unit
- bus_addr  input  5  byte address; bits [4:2] select the register, bits [1:0] are ignored
- bus_wdata  input  32  write data
- bus_we  input  1  write strobe, one cycle per access
- bus_re  input  1  read strobe, one cycle per access
- bus_rdata  output  32  registered read data, valid the cycle after bus_re

## Operation
- Registers (word index: name):
  - 0 PENDING: read-only bits [NUM_SRC-1:0]; a write-1 clears edge-type bits only.
  - 1 ENABLE: read/write.
  - 2 TRIGGER: read/write; 1 = rising edge, 0 = level-high.
  - 3 CLAIM: read-only; bits [4:0] = claimed ID, 0 when none; reading has no side effect.
  - 4 COMPLETE: write-only; bits [4:0] = ID; reads return 0.
  - 5..7: unmapped; reads return 0 and writes are ignored.
  - Bits at and above NUM_SRC always read 0.
- Synchronizer: two flops per source (s1, s2), plus a third flop s3 that holds the previous s2 for edge detection.
- Pending bit k:
  - Edge type: set when s2 & ~s3. Cleared by a PENDING write-1 or by a claim of ID k+1. If a set and a clear occur in the same cycle, the set wins.
  - Level type: pending[k] = s2[k], combinational view of the flop, and is not affected by writes.
  - Changing TRIGGER from edge to level leaves the stale edge latch in place, but the latch is ignored while the source is level type.
- Eligible set = pending & ENABLE & ~gate. The gate bit of the claimed source is held at 1 while it is claimed.
- FSM:
  - IDLE: meip_next = |eligible. On irq_ack, capture winner = lowest-index eligible bit.
    - If the set is non-empty: claim_id <= winner ID, clear the edge pending bit, go to CLAIMED.
    - If the set is empty (the race where software cleared it): stay in IDLE with claim_id = 0.
  - CLAIMED: meip_next = 0 and irq_ack is ignored.
    - A COMPLETE write whose ID equals claim_id sets claim_id <= 0, releases the gate and returns to IDLE.
    - A COMPLETE write with a mismatched ID is ignored.
- A level source that is still high after complete re-requests immediately: it is eligible again in IDLE.
- A PENDING W1C or ENABLE write that empties the eligible set drops meip on the next edge.

## Timing
- Reset (asynchronous, on reset_n low) values:
  - meip = 0, bus_rdata = 0, claim_id = 0, state = IDLE.
  - PENDING latches, ENABLE, TRIGGER, gate and all synchronizer flops = 0.
- Source to meip, edge type: src rises before edge E0.
  - s1 = 1 at E0, s2 = 1 at E1, pending set at E2, meip = 1 at E3.
  - Total: 4 edges from the first sampling edge.
- Source to meip, level type: same path; pending follows s2 at E1, so meip = 1 at E2.
- irq_ack high in cycle C: claim and state change at the end of C, and meip = 0 from C+1.
- COMPLETE written in cycle C: IDLE from C+1, and meip can reassert at the end of C+1.
- Read: bus_re in cycle C gives bus_rdata valid from C+1 and held until the next read.
- Simultaneous bus_we and irq_ack: both take effect.
  - An ENABLE write in the same cycle does not alter the winner computed from the old ENABLE.
- Reset asserted mid-claim: everything returns to reset values, and any in-flight edges are lost.

## Test plan
- Reset: with reset_n low, force src_irq = all-1s → meip = 0 and every register reads 0. Release reset with ENABLE = 0 → meip stays 0.
- Edge source: TRIGGER = 0x1, ENABLE = 0x1, pulse src_irq[0] for 1 cycle → meip = 1 exactly 4 edges later. Pulse irq_ack → meip = 0 next cycle, CLAIM reads 1, PENDING reads 0. Write COMPLETE = 1 → CLAIM reads 0.
- Priority: level sources 3 and 5 (bits 2, 4) high and enabled, then irq_ack → CLAIM = 3. Complete ID 3 with source 3 still high → meip reasserts, next ack gives CLAIM = 3 again. Drop bit 2, complete, ack → CLAIM = 5.
- Wrong complete: claimed ID 2, write COMPLETE = 4 → state stays CLAIMED and meip stays 0 despite other pending. Write COMPLETE = 2 → meip = 1 on the following edge.
- Race: edge pending on ID 1; in the same cycle, W1C PENDING = 0x1 and an edge on src_irq[0] → PENDING bit stays 1. Separately, clear pending, then irq_ack one cycle later → CLAIM = 0 and state stays IDLE.
- Async reset mid-claim: with CLAIM = 2, drop reset_n between edges → meip, bus_rdata and CLAIM read 0 immediately after release.

Source files
------------

// File: rtl/ext_irq_ctrl.sv
// rtl/ext_irq_ctrl.sv - external interrupt controller: sync, pending latch, fixed-priority claim/complete
module ext_irq_ctrl #(
    parameter int NUM_SRC = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               irq_ack,
    output logic               meip,
    input  logic [4:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    input  logic               bus_we,
    input  logic               bus_re,
    output logic [31:0]        bus_rdata
);

    typedef enum logic {IDLE, CLAIMED} state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
    logic [NUM_SRC-1:0] lat_q, lat_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic [NUM_SRC-1:0] trig_q, trig_d;
    logic [NUM_SRC-1:0] gate_q, gate_d;
    logic [4:0]         claim_q, claim_d;
    logic               meip_q, meip_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [NUM_SRC-1:0] pend, elig, win_oh, claim_clr, w1c_mask;
    logic [4:0]         win_id;
    logic               any_elig;
    logic [2:0]         reg_idx;
    logic               wr_pend, wr_en, wr_trig, wr_cmpl;
    logic               unused_bits;

    assign reg_idx     = bus_addr[4:2];
    assign wr_pend     = bus_we && (reg_idx == 3'd0);
    assign wr_en       = bus_we && (reg_idx == 3'd1);
    assign wr_trig     = bus_we && (reg_idx == 3'd2);
    assign wr_cmpl     = bus_we && (reg_idx == 3'd4);
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:NUM_SRC]};

    // Level sources expose s2 directly; a stale edge latch stays hidden behind them.
    assign pend     = (trig_q & lat_q) | (~trig_q & s2_q);
    assign elig     = pend & en_q & ~gate_q;
    assign any_elig = |elig;
    assign w1c_mask = wr_pend ? bus_wdata[NUM_SRC-1:0] : '0;

    always_comb begin
        win_oh = '0;
        win_id = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (elig[k]) begin
                win_oh    = '0;
                win_oh[k] = 1'b1;
                win_id    = 5'(k + 1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        claim_d   = claim_q;
        gate_d    = gate_q;
        meip_d    = 1'b0;
        claim_clr = '0;
        case (state_q)
            IDLE: begin
                meip_d = any_elig && !irq_ack;
                if (irq_ack && any_elig) begin
                    state_d   = CLAIMED;
                    claim_d   = win_id;
                    gate_d    = win_oh;
                    claim_clr = win_oh & trig_q;
                end
            end
            CLAIMED: begin
                if (wr_cmpl && (bus_wdata[4:0] == claim_q)) begin
                    state_d = IDLE;
                    claim_d = '0;
                    gate_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge in the same cycle as a clear keeps the bit set.
    assign lat_d  = (lat_q & ~(w1c_mask & trig_q) & ~claim_clr) | (s2_q & ~s3_q & trig_q);
    assign en_d   = wr_en   ? bus_wdata[NUM_SRC-1:0] : en_q;
    assign trig_d = wr_trig ? bus_wdata[NUM_SRC-1:0] : trig_q;

    always_comb begin
        rdata_d = rdata_q;
        if (bus_re) begin
            case (reg_idx)
                3'd0:    rdata_d = 32'(pend);
                3'd1:    rdata_d = 32'(en_q);
                3'd2:    rdata_d = 32'(trig_q);
                3'd3:    rdata_d = {27'd0, claim_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            lat_q   <= '0;
            en_q    <= '0;
            trig_q  <= '0;
            gate_q  <= '0;
            claim_q <= '0;
            meip_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= src_irq;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            lat_q   <= lat_d;
            en_q    <= en_d;
            trig_q  <= trig_d;
            gate_q  <= gate_d;
            claim_q <= claim_d;
            meip_q  <= meip_d;
            rdata_q <= rdata_d;
        end
    end

    assign meip      = meip_q;
    assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// tb/tb_ext_irq_ctrl.sv - directed and random checks of ext_irq_ctrl against a behavioural model
module tb_ext_irq_ctrl;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  src_irq;
    logic          irq_ack;
    logic          meip;
    logic [4:0]    bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_we;
    logic          bus_re;
    logic [31:0]   bus_rdata;

    int total = 0;
    int bad   = 0;

    ext_irq_ctrl #(.NUM_SRC(N)) dut (
        .clk(clk), .reset_n(reset_n), .src_irq(src_irq), .irq_ack(irq_ack), .meip(meip),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural model: sample history, edge latches, config and claimed ID (0 = idle).
    int          hist [3][N];
    int          latch[N];
    int          en   [N];
    int          trig [N];
    int          m_claim;
    int          m_meip;
    longint      m_rdata;

    function automatic int pend_bit(int k);
        return (trig[k] != 0) ? latch[k] : hist[1][k];
    endfunction

    function automatic longint reg_val(int idx);
        longint v = 0;
        for (int k = 0; k < N; k++) begin
            if (idx == 0 && pend_bit(k) != 0) v += longint'(1) << k;
            if (idx == 1 && en[k] != 0)       v += longint'(1) << k;
            if (idx == 2 && trig[k] != 0)     v += longint'(1) << k;
        end
        if (idx == 3) v = m_claim;
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                hist[0][k] = 0; hist[1][k] = 0; hist[2][k] = 0;
                latch[k] = 0; en[k] = 0; trig[k] = 0;
            end
            m_claim = 0;
            m_meip  = 0;
            m_rdata = 0;
        end else begin
            int winner;
            int idx;
            int next_latch[N];
            winner = 0;
            idx = int'(bus_addr) / 4;
            if (m_claim == 0)
                for (int k = N - 1; k >= 0; k--)
                    if (pend_bit(k) != 0 && en[k] != 0) winner = k + 1;
            if (bus_re) m_rdata = (idx <= 3) ? reg_val(idx) : 0;
            for (int k = 0; k < N; k++) begin
                next_latch[k] = latch[k];
                if (trig[k] != 0 && bus_we && idx == 0 && bus_wdata[k]) next_latch[k] = 0;
                if (trig[k] != 0 && irq_ack && winner == k + 1)        next_latch[k] = 0;
                if (trig[k] != 0 && hist[1][k] == 1 && hist[2][k] == 0) next_latch[k] = 1;
            end
            m_meip = (winner != 0 && !irq_ack) ? 1 : 0;
            if (m_claim == 0 && irq_ack && winner != 0) m_claim = winner;
            else if (m_claim != 0 && bus_we && idx == 4 && int'(bus_wdata[4:0]) == m_claim) m_claim = 0;
            for (int k = 0; k < N; k++) begin
                latch[k] = next_latch[k];
                if (bus_we && idx == 1) en[k]   = bus_wdata[k];
                if (bus_we && idx == 2) trig[k] = bus_wdata[k];
                hist[2][k] = hist[1][k];
                hist[1][k] = hist[0][k];
                hist[0][k] = src_irq[k];
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("meip_vs_model", longint'(meip), longint'(m_meip));
            chk("rdata_vs_model", longint'(bus_rdata), m_rdata);
        end
    end

    // All tasks start and end just after a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = 5'(idx * 4); bus_wdata = d;
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        bus_re = 1'b1; bus_addr = 5'(idx * 4 + 1);
        @(negedge clk);
        bus_re = 1'b0;
        d = bus_rdata;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        reset_n = 1'b0; src_irq = '1; irq_ack = 1'b0;
        bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;

        idle(3);
        chk("reset_meip", longint'(meip), 0);
        chk("reset_rdata", longint'(bus_rdata), 0);
        reset_n = 1'b1;
        idle(4);
        chk("post_reset_meip", longint'(meip), 0);
        rd(0, r);
        chk("post_reset_pending_level", longint'(r), 64'hFFFF);
        src_irq = '0;
        idle(3);

        // Edge source: meip four edges after the first sampling edge.
        wr(2, 32'h1); wr(1, 32'h1);
        src_irq[0] = 1'b1; idle(1); src_irq[0] = 1'b0;
        idle(2);
        chk("edge_meip_not_yet", longint'(meip), 0);
        idle(1);
        chk("edge_meip_on_e3", longint'(meip), 1);
        ack();
        chk("edge_meip_after_ack", longint'(meip), 0);
        rd(3, r); chk("edge_claim", longint'(r), 1);
        rd(0, r); chk("edge_pending_cleared", longint'(r), 0);
        wr(4, 32'd1);
        rd(3, r); chk("edge_claim_after_complete", longint'(r), 0);

        // Priority between level sources 3 and 5.
        wr(2, 32'h0); wr(1, 32'h14); src_irq = 16'h0014;
        idle(3);
        chk("prio_meip", longint'(meip), 1);
        ack(); rd(3, r); chk("prio_claim_3", longint'(r), 3);
        wr(4, 32'd3); idle(2);
        chk("prio_rerequest", longint'(meip), 1);
        ack(); rd(3, r); chk("prio_claim_3_again", longint'(r), 3);
        src_irq = 16'h0010; idle(3);
        wr(4, 32'd3); idle(2);
        ack(); rd(3, r); chk("prio_claim_5", longint'(r), 5);
        wr(4, 32'd5); src_irq = '0; idle(3);

        // Mismatched complete leaves the claim in place.
        wr(1, 32'h0A); src_irq = 16'h000A; idle(3);
        ack(); rd(3, r); chk("wrong_claim_2", longint'(r), 2);
        wr(4, 32'd4); idle(2);
        chk("wrong_meip_held", longint'(meip), 0);
        rd(3, r); chk("wrong_still_claimed", longint'(r), 2);
        wr(4, 32'd2); idle(1);
        chk("wrong_then_right_meip", longint'(meip), 1);
        src_irq = '0; idle(3);

        // Set/clear race on an edge latch, then an ack against an emptied set.
        wr(1, 32'h1); wr(2, 32'h1);
        src_irq[0] = 1'b1; idle(1); src_irq[0] = 1'b0; idle(6);
        src_irq[0] = 1'b1; idle(1); src_irq[0] = 1'b0; idle(1);
        wr(0, 32'h1);
        rd(0, r); chk("race_set_wins", longint'(r & 32'h1), 1);
        wr(0, 32'h1);
        ack();
        chk("race_meip", longint'(meip), 0);
        rd(3, r); chk("race_claim_none", longint'(r), 0);

        // Asynchronous reset while a claim is outstanding.
        wr(2, 32'h0); wr(1, 32'h2); src_irq = 16'h0002; idle(3);
        ack(); rd(3, r); chk("areset_claim_before", longint'(r), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_meip", longint'(meip), 0);
        chk("areset_rdata", longint'(bus_rdata), 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        rd(3, r); chk("areset_claim_after", longint'(r), 0);
        chk("areset_meip_after", longint'(meip), 0);
        src_irq = '0; idle(3);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            int op;
            if ($urandom_range(3) == 0) src_irq = src_irq ^ N'($urandom & $urandom);
            irq_ack = ($urandom_range(7) == 0);
            op = int'($urandom_range(9));
            bus_we = 1'b0; bus_re = 1'b0;
            bus_addr = 5'($urandom);
            bus_wdata = $urandom;
            if (op < 3) begin
                bus_we = 1'b1;
                if (op == 0 && m_claim != 0) begin
                    bus_addr = 5'd16;
                    bus_wdata = ($urandom_range(3) == 0) ? 32'($urandom_range(N)) : 32'(m_claim);
                end
            end else if (op < 6) begin
                bus_re = 1'b1;
            end
            if ($urandom_range(499) == 0) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
            @(negedge clk);
        end
        irq_ack = 1'b0; bus_we = 1'b0; bus_re = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout: bench did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
